// File: rtl/logic_pipe.sv
// Pipelined bitwise logic unit with a zero flag and valid/ready handshakes on both sides.
// Each stage register collapses bubbles, so up to STAGES results are buffered under a stall.
module logic_pipe #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] inA,
  input  logic [WIDTH-1:0] inB,
  input  logic [2:0]       op,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out,
  output logic             zero,
  output logic             out_valid,
  input  logic             out_ready
);

  function automatic logic [WIDTH-1:0] logic_op(input logic [2:0] sel,
                                                input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
    case (sel)
      3'b000:  logic_op = a & b;
      3'b001:  logic_op = a | b;
      3'b010:  logic_op = a ^ b;
      3'b011:  logic_op = ~(a | b);
      3'b100:  logic_op = a & ~b;
      3'b101:  logic_op = a | ~b;
      3'b110:  logic_op = a;
      default: logic_op = ~a;
    endcase
  endfunction

  logic [WIDTH-1:0]  res_p0;
  logic              zero_p0;
  logic [STAGES-1:0] vld;
  logic [STAGES-1:0] zro;
  logic [WIDTH-1:0]  dat [STAGES];
  logic [STAGES-1:0] rdy;

  // stage 0 input: compute result and its zero flag
  always_comb begin
    res_p0  = logic_op(op, inA, inB);
    zero_p0 = ~|res_p0;
  end

  // A stage can load when it or any stage downstream of it is empty, or the sink pops.
  always_comb begin
    logic acc;
    acc = out_ready;
    rdy = '0;
    for (int i = STAGES - 1; i >= 0; i--) begin
      acc    = acc | ~vld[i];
      rdy[i] = acc;
    end
  end

  assign in_ready = rdy[0];

  // stage registers s0..s(STAGES-1)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld <= '0;
      zro <= '0;
      for (int i = 0; i < STAGES; i++) dat[i] <= '0;
    end else begin
      for (int i = 0; i < STAGES; i++) begin
        if (rdy[i]) begin
          if (i == 0) begin
            vld[0] <= in_valid;
            dat[0] <= res_p0;
            zro[0] <= zero_p0;
          end else begin
            vld[i] <= vld[i-1];
            dat[i] <= dat[i-1];
            zro[i] <= zro[i-1];
          end
        end
      end
    end
  end

  // output stage: driven straight from the last register
  assign out       = dat[STAGES-1];
  assign zero      = zro[STAGES-1];
  assign out_valid = vld[STAGES-1];

endmodule

// File: tb/tb_logic_pipe.sv
// Directed bench for logic_pipe: a 32-bit/2-stage instance and a 1-bit/1-stage instance.
module tb_logic_pipe;

  logic        clk;
  logic        rst;
  logic [31:0] inA, inB;
  logic [2:0]  op;
  logic        in_valid, in_ready;
  logic [31:0] out;
  logic        zero, out_valid, out_ready;

  logic        a1, b1, iv1, ir1, o1, z1, ov1, or1;
  logic [2:0]  op1;

  int checks   = 0;
  int failures = 0;

  logic_pipe #(.WIDTH(32), .STAGES(2)) dut (
    .clk(clk), .rst(rst), .inA(inA), .inB(inB), .op(op),
    .in_valid(in_valid), .in_ready(in_ready), .out(out), .zero(zero),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  logic_pipe #(.WIDTH(1), .STAGES(1)) dut1 (
    .clk(clk), .rst(rst), .inA(a1), .inB(b1), .op(op1),
    .in_valid(iv1), .in_ready(ir1), .out(o1), .zero(z1),
    .out_valid(ov1), .out_ready(or1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] exp_ops [8];
  logic [31:0] v [4];
  logic [3:0]  and_tt;

  initial begin
    exp_ops[0] = 32'h00F0_000F; exp_ops[1] = 32'hFFF0_0FFF;
    exp_ops[2] = 32'hFF00_0FF0; exp_ops[3] = 32'h000F_F000;
    exp_ops[4] = 32'hF000_00F0; exp_ops[5] = 32'hF0FF_F0FF;
    exp_ops[6] = 32'hF0F0_00FF; exp_ops[7] = 32'h0F0F_FF00;
    v[0] = 32'h1111_0001; v[1] = 32'h2222_0002; v[2] = 32'h3333_0003; v[3] = 32'h4444_0004;
    and_tt = 4'b1000;

    rst = 1'b1; inA = '0; inB = '0; op = '0; in_valid = 1'b0; out_ready = 1'b1;
    a1 = 1'b0; b1 = 1'b0; op1 = 3'b000; iv1 = 1'b0; or1 = 1'b1;

    // reset state
    #3;
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_out", out, 32'd0);
    check("rst_in_ready", {31'b0, in_ready}, 32'd1);
    #9 rst = 1'b0;
    tick();

    // reset mid-operation
    inA = 32'hDEAD_BEEF; inB = 32'hFFFF_0000; op = 3'b000; in_valid = 1'b1;
    tick();
    op = 3'b001;
    tick();
    check("mid_pre_valid", {31'b0, out_valid}, 32'd1);
    check("mid_pre_out", out, 32'hDEAD_0000);
    #2;
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("mid_rst_valid", {31'b0, out_valid}, 32'd0);
    check("mid_rst_out", out, 32'd0);
    check("mid_rst_zero", {31'b0, zero}, 32'd0);
    check("mid_rst_ready", {31'b0, in_ready}, 32'd1);
    tick();
    check("mid_rst_hold_valid", {31'b0, out_valid}, 32'd0);
    #2 rst = 1'b0;
    #1;
    check("mid_rel_ready", {31'b0, in_ready}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("mid_no_stale", {31'b0, out_valid}, 32'd0);
    end

    // all ops back-to-back
    inA = 32'hF0F0_00FF; inB = 32'h0FF0_0F0F; out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (i < 8) begin
        op = 3'(i);
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (i < 8) check("ops_in_ready", {31'b0, in_ready}, 32'd1);
      tick();
      if (i >= 1 && i <= 8) begin
        check("ops_valid", {31'b0, out_valid}, 32'd1);
        check("ops_out", out, exp_ops[i-1]);
        check("ops_zero", {31'b0, zero}, 32'd0);
      end
    end
    check("ops_drained", {31'b0, out_valid}, 32'd0);

    // zero flag
    inA = 32'h1234_5678; inB = 32'h1234_5678; op = 3'b010; in_valid = 1'b1;
    tick();
    op = 3'b001;
    tick();
    in_valid = 1'b0;
    check("zf_xor_out", out, 32'd0);
    check("zf_xor_zero", {31'b0, zero}, 32'd1);
    check("zf_xor_valid", {31'b0, out_valid}, 32'd1);
    tick();
    check("zf_or_out", out, 32'h1234_5678);
    check("zf_or_zero", {31'b0, zero}, 32'd0);
    tick();

    // back-pressure, then simultaneous push/pop when full
    out_ready = 1'b0; op = 3'b110; inB = '0;
    inA = v[0]; in_valid = 1'b1;
    #1 check("bp_rdy0", {31'b0, in_ready}, 32'd1);
    tick();
    inA = v[1];
    #1 check("bp_rdy1", {31'b0, in_ready}, 32'd1);
    tick();
    inA = v[2];
    #1 check("bp_full_rdy", {31'b0, in_ready}, 32'd0);
    check("bp_hold_out", out, v[0]);
    tick();
    check("bp_hold_out2", out, v[0]);
    check("bp_hold_valid", {31'b0, out_valid}, 32'd1);
    check("bp_still_full", {31'b0, in_ready}, 32'd0);
    out_ready = 1'b1;
    #1 check("sim_in_ready", {31'b0, in_ready}, 32'd1);
    tick();
    check("sim_out", out, v[1]);
    check("sim_valid", {31'b0, out_valid}, 32'd1);
    out_ready = 1'b0;
    #1 check("sim_occ2", {31'b0, in_ready}, 32'd0);
    out_ready = 1'b1;
    inA = v[3];
    #1 check("drain_rdy", {31'b0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    check("drain_v2", out, v[2]);
    tick();
    check("drain_v3", out, v[3]);
    check("drain_v3_valid", {31'b0, out_valid}, 32'd1);
    tick();
    check("drain_empty", {31'b0, out_valid}, 32'd0);

    // WIDTH=1, STAGES=1 AND truth table
    or1 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      logic [1:0] ab;
      ab = 2'(i);
      a1 = ab[1]; b1 = ab[0]; iv1 = 1'b1;
      tick();
      check("w1_out", {31'b0, o1}, {31'b0, and_tt[i]});
      check("w1_zero", {31'b0, z1}, {31'b0, ~and_tt[i]});
      check("w1_valid", {31'b0, ov1}, 32'd1);
    end
    or1 = 1'b0;
    #1 check("w1_rdy_stall", {31'b0, ir1}, 32'd0);
    or1 = 1'b1;
    #1 check("w1_rdy_pop", {31'b0, ir1}, 32'd1);
    iv1 = 1'b0;
    tick();
    or1 = 1'b0;
    #1 check("w1_rdy_empty", {31'b0, ir1}, 32'd1);
    check("w1_empty_valid", {31'b0, ov1}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
